// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side FIFO slice.
// The drain FSM states live here so the bench and other UART blocks agree on names.
package uart_pkg;

   localparam int CLKS_PER_BIT = 2813;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_ACTIVE = 2'd1,
      WAIT_DONE   = 2'd2
   } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port byte storage: synchronous write, combinational read.
// The array is deliberately left without reset so it can map onto distributed RAM.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clock,
   input  logic                  i_wr_en,
   input  logic [DEPTH_LOG2-1:0] i_wr_addr,
   input  byte_t                 i_wr_data,
   input  logic [DEPTH_LOG2-1:0] i_rd_addr,
   output byte_t                 o_rd_data
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   byte_t mem [DEPTH];

   always_ff @(posedge clock) begin
      if (i_wr_en) begin
         mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that buffers uart_rx output and feeds uart_tx one byte per o_done handshake.
// Optional almost-full flag is enabled with `define UART_TX_FIFO_ALMOST_FULL_EN.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int AF_THRESH  = 12
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                i_wr_en,
   input  byte_t               i_wr_data,
   input  logic                i_tx_active,
   input  logic                i_tx_done,
   output logic                o_tx_data_avail,
   output byte_t               o_tx_data_byte,
   output logic                o_empty,
   output logic                o_full,
   output logic [DEPTH_LOG2:0] o_count,
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
   output logic                o_almost_full,
`endif
   output logic                o_overflow
);

   localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   tx_state_e             state_q, state_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  empty_q, full_q, overflow_q, overflow_d;
   logic                  avail_q;
   byte_t                 byte_q, byte_d;
   byte_t                 head_data;
   logic                  pop, push;

   uart_fifo_mem #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_mem (
      .clock     (clock),
      .i_wr_en   (push),
      .i_wr_addr (wr_ptr_q),
      .i_wr_data (i_wr_data),
      .i_rd_addr (rd_ptr_q),
      .o_rd_data (head_data)
   );

   // Launch only from IDLE; both wait states fall back to IDLE on o_done.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if ((count_q != '0) && !i_tx_active) begin
               pop     = 1'b1;
               state_d = WAIT_ACTIVE;
            end
         end
         WAIT_ACTIVE: begin
            if (i_tx_done) begin
               state_d = IDLE;
            end else if (i_tx_active) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (i_tx_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
   always_comb begin
      push       = i_wr_en && (!full_q || pop);
      overflow_d = overflow_q || (i_wr_en && full_q && !pop);
      wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      byte_d     = pop  ? head_data : byte_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         avail_q    <= 1'b0;
         byte_q     <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= (count_d == '0);
         full_q     <= (count_d == FULL_CNT);
         overflow_q <= overflow_d;
         avail_q    <= pop;
         byte_q     <= byte_d;
      end
   end

`ifdef UART_TX_FIFO_ALMOST_FULL_EN
   logic almost_full_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         almost_full_q <= 1'b0;
      end else begin
         almost_full_q <= (int'(count_d) >= AF_THRESH);
      end
   end

   assign o_almost_full = almost_full_q;
`endif

   assign o_tx_data_avail = avail_q;
   assign o_tx_data_byte  = byte_q;
   assign o_empty         = empty_q;
   assign o_full          = full_q;
   assign o_count         = count_q;
   assign o_overflow      = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios then random traffic,
// compared each cycle against a queue-based model of the FIFO and launch handshake.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;

   logic       clock = 1'b0;
   logic       reset;
   logic       i_wr_en;
   logic [7:0] i_wr_data;
   logic       i_tx_active;
   logic       i_tx_done;
   logic       o_tx_data_avail;
   logic [7:0] o_tx_data_byte;
   logic       o_empty;
   logic       o_full;
   logic [4:0] o_count;
   logic       o_overflow;
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
   logic       o_almost_full;
`endif

   int passCount  = 0;
   int totalCount = 0;

   logic [7:0] modelQ[$];
   bit         busy;
   bit         expOvf;
   bit         expAvail;
   logic [7:0] expByte;
   string      phase;

   always #5 clock = ~clock;

   uart_tx_fifo dut (
      .clock           (clock),
      .reset           (reset),
      .i_wr_en         (i_wr_en),
      .i_wr_data       (i_wr_data),
      .i_tx_active     (i_tx_active),
      .i_tx_done       (i_tx_done),
      .o_tx_data_avail (o_tx_data_avail),
      .o_tx_data_byte  (o_tx_data_byte),
      .o_empty         (o_empty),
      .o_full          (o_full),
      .o_count         (o_count),
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
      .o_almost_full   (o_almost_full),
`endif
      .o_overflow      (o_overflow)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s/%s observed=%0h expected=%0h", phase, tag, observed, expected);
   endtask

   // Model: a launch happens whenever nothing is in flight, data is queued and tx is idle.
   task automatic modelUpdate(input bit wr, input logic [7:0] data, input bit act, input bit dn, input bit rst);
      bit launch;
      bit wasFull;
      if (rst) begin
         modelQ.delete();
         busy     = 0;
         expOvf   = 0;
         expAvail = 0;
         expByte  = 8'h00;
      end else begin
         launch  = !busy && (modelQ.size() > 0) && !act;
         wasFull = (modelQ.size() == DEPTH);
         if (launch) expByte = modelQ.pop_front();
         if (wr) begin
            if (!wasFull || launch) modelQ.push_back(data);
            else expOvf = 1;
         end
         if (busy && dn) busy = 0;
         if (launch) busy = 1;
         expAvail = launch;
      end
   endtask

   task automatic applyStimulus(input bit wr, input logic [7:0] data, input bit act, input bit dn, input bit rst = 0);
      reset       = rst;
      i_wr_en     = wr;
      i_wr_data   = data;
      i_tx_active = act;
      i_tx_done   = dn;
      @(posedge clock);
      modelUpdate(wr, data, act, dn, rst);
      #1;
      checkOutput("avail", o_tx_data_avail, expAvail);
      checkOutput("byte",  o_tx_data_byte,  expByte);
      checkOutput("count", o_count,         modelQ.size());
      checkOutput("empty", o_empty,         modelQ.size() == 0);
      checkOutput("full",  o_full,          modelQ.size() == DEPTH);
      checkOutput("ovf",   o_overflow,      expOvf);
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
      checkOutput("afull", o_almost_full,   modelQ.size() >= 12);
`endif
   endtask

   task automatic drainOne();
      applyStimulus(0, 8'h00, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0);
      applyStimulus(0, 8'h00, 0, 1);
   endtask

   initial begin
      phase = "reset";
      applyStimulus(0, 8'h00, 0, 0, 1);
      applyStimulus(0, 8'h00, 0, 0, 1);

      phase = "single";
      applyStimulus(1, 8'h41, 0, 0);
      applyStimulus(0, 8'h00, 0, 0);
      checkOutput("launch41", o_tx_data_byte, 8'h41);
      applyStimulus(0, 8'h00, 0, 0);
      for (int i = 0; i < 10; i++) applyStimulus(0, 8'h00, 1, 0);
      applyStimulus(0, 8'h00, 0, 1);
      applyStimulus(0, 8'h00, 0, 0);

      phase = "burst3";
      applyStimulus(1, 8'h01, 1, 0);
      applyStimulus(1, 8'h02, 1, 0);
      applyStimulus(1, 8'h03, 1, 0);
      checkOutput("cnt3", o_count, 5'd3);
      for (int i = 0; i < 3; i++) drainOne();

      phase = "overflow";
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'h80 + 8'(i), 1, 0);
      applyStimulus(1, 8'hFF, 1, 0);
      checkOutput("ovfSet", o_overflow, 1'b1);
      for (int i = 0; i < DEPTH + 1; i++) begin
         drainOne();
         checkOutput("noFF", o_tx_data_byte != 8'hFF, 1'b1);
      end
      checkOutput("ovfSticky", o_overflow, 1'b1);

      phase = "fullPop";
      applyStimulus(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'h20 + 8'(i), 1, 0);
      applyStimulus(1, 8'h5A, 0, 0);
      checkOutput("cnt16", o_count, 5'd16);
      checkOutput("noOvf", o_overflow, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0);
      applyStimulus(0, 8'h00, 0, 1);
      for (int i = 0; i < DEPTH; i++) drainOne();
      checkOutput("last5A", o_tx_data_byte, 8'h5A);

      phase = "midReset";
      for (int i = 0; i < 5; i++) applyStimulus(1, 8'hC0 + 8'(i), 1, 0);
      applyStimulus(0, 8'h00, 0, 0);
      applyStimulus(0, 8'h00, 1, 0);
      applyStimulus(0, 8'h00, 1, 0);
      checkOutput("cnt4", o_count, 5'd4);
      applyStimulus(0, 8'h00, 1, 0, 1);
      applyStimulus(0, 8'h00, 1, 1);
      applyStimulus(0, 8'h00, 0, 0);
      checkOutput("postRstCnt", o_count, 5'd0);

      phase = "random";
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 99) < 50,
                       $urandom_range(0, 99) < 20, $urandom_range(0, 199) == 0);
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO plus drain state machine between the receive path (uart_rx o_data_avail/o_data_byte) and the transmitter (uart_tx i_data_avail/i_data_byte/o_active/o_done).
- Absorbs bytes that arrive while uart_tx is still shifting, so no byte is lost when rx bursts outrun tx.
- Launches at most one byte into uart_tx at a time and waits for o_done before launching the next.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries)
- AF_THRESH, 12, almost-full threshold in entries (used only with the optional feature)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_wr_en  in  1  write strobe, one byte per asserted cycle; connects to uart_rx o_data_avail
- i_wr_data  in  8  byte to enqueue
- i_tx_active  in  1  from uart_tx o_active
- i_tx_done  in  1  from uart_tx o_done, one-cycle pulse
- o_tx_data_avail  out  1  one-cycle launch pulse to uart_tx i_data_avail
- o_tx_data_byte  out  8  byte to uart_tx i_data_byte; held stable from launch until done
- o_empty  out  1  FIFO holds 0 entries
- o_full  out  1  FIFO holds 2^DEPTH_LOG2 entries
- o_count  out  DEPTH_LOG2+1  current occupancy
- o_overflow  out  1  sticky; a write was dropped

Behaviour:
- Reset (clock edge with reset=1):
  - Pointers and count = 0; state = IDLE.
  - o_tx_data_avail = 0, o_tx_data_byte = 0x00, o_empty = 1, o_full = 0, o_overflow = 0.
  - FIFO storage is not cleared.
  - Reset overrides every other event in the same cycle.
- Write acceptance: accepted when (!o_full) or a pop occurs in the same cycle.
  - A write while full with no pop is dropped and sets o_overflow.
  - o_overflow stays set until reset.
- Pointers: DEPTH_LOG2 bits, wrap modulo depth. Count is updated +1, -1 or unchanged (simultaneous push and pop).
- Flags o_empty, o_full and o_count are registered and consistent with count after each edge.
- FSM states are IDLE, WAIT_ACTIVE and WAIT_DONE:
  - IDLE, when count>0 and i_tx_active=0: register o_tx_data_byte <= head entry, set o_tx_data_avail=1 for exactly one cycle, pop, go to WAIT_ACTIVE.
  - WAIT_ACTIVE: on i_tx_done go to IDLE; else on i_tx_active go to WAIT_DONE.
  - WAIT_DONE: on i_tx_done go to IDLE.
- No fall-through:
  - A write sampled at edge k into an empty FIFO produces o_tx_data_avail high between edges k+1 and k+2.
  - Next launch is no earlier than the cycle after i_tx_done is seen.
- o_tx_data_byte changes only at launch.
- i_tx_done in IDLE is ignored.
- Reset mid-transfer returns to IDLE; a later stray i_tx_done is ignored.

Optional Feature:
- Macro UART_TX_FIFO_ALMOST_FULL_EN.
- Defined: adds output o_almost_full (1 bit), registered, =1 when count >= AF_THRESH, reset 0.
- Undefined: the port and logic are absent; AF_THRESH is unused.

Decomposition:
- Package uart_pkg:
  - CLKS_PER_BIT default constant (2813, 27 MHz / 9600 baud)
  - FSM state enum for IDLE/WAIT_ACTIVE/WAIT_DONE
  - byte typedef (8 bits)
- Sub-module uart_fifo_mem:
  - Simple dual-port storage, 2^DEPTH_LOG2 x 8.
  - Synchronous write, combinational read at the read pointer.
  - No reset on the array.
- Pointer, count and FSM logic stay in uart_tx_fifo.

Test Plan:
- Reset pulse -> o_empty=1, o_full=0, o_count=0, o_tx_data_avail=0, o_tx_data_byte=0x00, o_overflow=0.
- Write 0x41 at edge k, tx idle -> o_tx_data_avail high only for cycle k+1..k+2, o_tx_data_byte=0x41. Then hold i_tx_active 10 cycles and pulse i_tx_done -> state IDLE, o_empty=1.
- Write 0x01, 0x02, 0x03 back-to-back while i_tx_active=1 -> o_count reaches 3 with no launches. Drains 0x01, 0x02, 0x03 in order, each launch only after the previous i_tx_done.
- Write 16 bytes with tx held busy, then 0xFF -> o_full=1, o_count=16, o_overflow=1, 0xFF never transmitted, o_overflow stays 1 after draining.
- FIFO full, tx idle, i_wr_en with 0x5A in the launch cycle -> write accepted, o_count stays 16, o_overflow=0, 0x5A is the last byte drained.
- reset asserted while in WAIT_DONE with 4 entries queued -> next cycle all outputs at reset values. A following i_tx_done produces no launch; o_count=0.
